// File: rtl/em_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// em_pipe_reg_if
// Bundle of every signal that crosses the Execute -> Memory pipeline register.
//   E_* : values produced by the Execute stage (driven by the core / bench)
//   M_* : registered Memory-stage copies plus the M-stage forwarding tuple
// Modports:
//   master : drives E_*, observes M_* (Execute side / testbench)
//   slave  : consumes E_*, drives M_* (the pipeline register itself)
// CNT_W sizes the debug retired-instruction counter and must match the
// CNT_W of the em_pipe_reg instance it is connected to.
// ---------------------------------------------------------------------------
interface em_pipe_reg_if #(
  parameter int CNT_W = 32
);
  // Execute-stage side
  logic             E_valid;
  logic [31:0]      E_PC;
  logic [31:0]      E_instruction;
  logic [31:0]      E_data_rt;
  logic [31:0]      E_addr_rt;
  logic [31:0]      E_addr_rd;
  logic [31:0]      E_Shift;
  logic [31:0]      E_ALUout;
  logic [1:0]       E_Tnew;
  logic [4:0]       E_RegWreg;
  logic [31:0]      E_RegWD;
  logic             E_RegWrite;

  // Memory-stage side
  logic [31:0]      M_PC;
  logic [31:0]      M_instruction;
  logic [31:0]      M_data_rt;
  logic [31:0]      M_addr_rt;
  logic [31:0]      M_addr_rd;
  logic [31:0]      M_Shift;
  logic [31:0]      M_ALUout;
  logic [1:0]       M_Tnew;
  logic [4:0]       M_RegWreg;
  logic [31:0]      M_RegWD;
  logic             M_RegWrite;
  logic             M_valid;
  logic             M_fwd_ok;
  logic [CNT_W-1:0] M_count;

  modport master (
    output E_valid, E_PC, E_instruction, E_data_rt, E_addr_rt, E_addr_rd,
           E_Shift, E_ALUout, E_Tnew, E_RegWreg, E_RegWD, E_RegWrite,
    input  M_PC, M_instruction, M_data_rt, M_addr_rt, M_addr_rd, M_Shift,
           M_ALUout, M_Tnew, M_RegWreg, M_RegWD, M_RegWrite, M_valid,
           M_fwd_ok, M_count
  );

  modport slave (
    input  E_valid, E_PC, E_instruction, E_data_rt, E_addr_rt, E_addr_rd,
           E_Shift, E_ALUout, E_Tnew, E_RegWreg, E_RegWD, E_RegWrite,
    output M_PC, M_instruction, M_data_rt, M_addr_rt, M_addr_rd, M_Shift,
           M_ALUout, M_Tnew, M_RegWreg, M_RegWD, M_RegWrite, M_valid,
           M_fwd_ok, M_count
  );
endinterface

// File: rtl/em_pipe_reg.sv
// ---------------------------------------------------------------------------
// em_pipe_reg
// Execute -> Memory pipeline register of the 5-stage MIPS core.
// Latches all Execute results, ages Tnew by one stage, and presents the
// M-stage forwarding tuple (M_RegWreg, M_RegWD, M_fwd_ok) to the hazard unit.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   en      : 1 = load from Execute, 0 = hold (stall)
//   flush   : synchronous bubble insertion, overrides en
//   bus     : em_pipe_reg_if.slave (E_* inputs, M_* outputs, M_count)
// Edge priority: reset > flush > hold > load. M_count survives a flush.
// ---------------------------------------------------------------------------
module em_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          flush,
  em_pipe_reg_if.slave  bus
);

  // Everything a flush clears lives in one struct so the bubble and the reset
  // value are the same constant.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] data_rt;
    logic [31:0] addr_rt;
    logic [31:0] addr_rd;
    logic [31:0] shift;
    logic [31:0] alu_out;
    logic [31:0] reg_wd;
    logic [1:0]  tnew;
    logic [4:0]  reg_wreg;
    logic        reg_write;
    logic        valid;
  } slot_t;

  // Bubble: a nop (instruction 0) at RESET_PC that writes nothing.
  localparam slot_t SLOT_RESET = '{pc: RESET_PC, default: '0};

  slot_t            slot_q;
  slot_t            slot_d;
  logic [CNT_W-1:0] count_q;

  // Next slot contents for a load.
  // NOTE: slot_d gets a full default before any field is overwritten, so no
  // path through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d             = SLOT_RESET;
    slot_d.pc          = bus.E_PC;
    slot_d.instruction = bus.E_instruction;
    slot_d.data_rt     = bus.E_data_rt;
    slot_d.addr_rt     = bus.E_addr_rt;
    slot_d.addr_rd     = bus.E_addr_rd;
    slot_d.shift       = bus.E_Shift;
    slot_d.alu_out     = bus.E_ALUout;
    slot_d.reg_wd      = bus.E_RegWD;
    // One stage of aging; a result already available stays at 0 instead of
    // wrapping to 3.
    slot_d.tnew        = (bus.E_Tnew == 2'd0) ? 2'd0 : bus.E_Tnew - 2'd1;
    // Hide the destination when nothing is written so the hazard unit never
    // matches against a stale register number.
    slot_d.reg_wreg    = bus.E_RegWrite ? bus.E_RegWreg : 5'd0;
    // A squashed slot may carry junk fields but must never commit a write.
    slot_d.reg_write   = bus.E_RegWrite & bus.E_valid;
    slot_d.valid       = bus.E_valid;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= SLOT_RESET;
      count_q <= '0;
    end else if (flush) begin
      // Counter deliberately untouched: it counts loads, not live slots.
      slot_q  <= SLOT_RESET;
    end else if (en) begin
      slot_q  <= slot_d;
      if (bus.E_valid) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.M_PC          = slot_q.pc;
  assign bus.M_instruction = slot_q.instruction;
  assign bus.M_data_rt     = slot_q.data_rt;
  assign bus.M_addr_rt     = slot_q.addr_rt;
  assign bus.M_addr_rd     = slot_q.addr_rd;
  assign bus.M_Shift       = slot_q.shift;
  assign bus.M_ALUout      = slot_q.alu_out;
  assign bus.M_RegWD       = slot_q.reg_wd;
  assign bus.M_Tnew        = slot_q.tnew;
  assign bus.M_RegWreg     = slot_q.reg_wreg;
  assign bus.M_RegWrite    = slot_q.reg_write;
  assign bus.M_valid       = slot_q.valid;
  assign bus.M_count       = count_q;

  // M-stage value may be forwarded only when it is a real, ready write to a
  // register other than $0. Built purely from registered state.
  assign bus.M_fwd_ok = slot_q.reg_write & (slot_q.reg_wreg != 5'd0) &
                        (slot_q.tnew == 2'd0) & slot_q.valid;

endmodule

// File: tb/tb_em_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_em_pipe_reg
// Self-checking bench for em_pipe_reg. A behavioural model of the register
// predicts the M-stage outputs for each driven cycle; predictions are queued
// when stimulus is applied and popped once the DUT has clocked. Scenario tasks
// add targeted checks against fixed values. A second instance with CNT_W=4
// exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_em_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] data_rt;
    logic [31:0] addr_rt;
    logic [31:0] addr_rd;
    logic [31:0] shift;
    logic [31:0] alu_out;
    logic [1:0]  tnew;
    logic [4:0]  reg_wreg;
    logic [31:0] reg_wd;
    logic        reg_write;
  } e_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] data_rt;
    logic [31:0] addr_rt;
    logic [31:0] addr_rd;
    logic [31:0] shift;
    logic [31:0] alu_out;
    logic [1:0]  tnew;
    logic [4:0]  reg_wreg;
    logic [31:0] reg_wd;
    logic        reg_write;
    logic        valid;
    logic        fwd_ok;
    logic [31:0] count;
  } m_t;

  logic clk = 1'b0;
  logic reset_n;
  logic en, flush;
  logic en4, flush4;

  int n_vec = 0;
  int n_err = 0;

  m_t mdl;
  m_t sb_q[$];

  em_pipe_reg_if #(.CNT_W(32)) bus ();
  em_pipe_reg_if #(.CNT_W(4))  bus4 ();

  em_pipe_reg #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .bus(bus.slave)
  );

  em_pipe_reg #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en4), .flush(flush4), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic m_t rst_m();
    m_t m = '0;
    m.pc = 32'h0000_3000;
    return m;
  endfunction

  function automatic m_t with_fwd(input m_t m);
    m_t r = m;
    r.fwd_ok = m.reg_write && (m.reg_wreg != 5'd0) && (m.tnew == 2'd0) && m.valid;
    return r;
  endfunction

  function automatic m_t model_next(input m_t cur, input logic en_v,
                                    input logic flush_v, input e_t e);
    m_t n = cur;
    if (flush_v) begin
      n       = rst_m();
      n.count = cur.count;
    end else if (en_v) begin
      n.pc          = e.pc;
      n.instruction = e.instruction;
      n.data_rt     = e.data_rt;
      n.addr_rt     = e.addr_rt;
      n.addr_rd     = e.addr_rd;
      n.shift       = e.shift;
      n.alu_out     = e.alu_out;
      n.reg_wd      = e.reg_wd;
      case (e.tnew)
        2'd0:    n.tnew = 2'd0;
        2'd1:    n.tnew = 2'd0;
        2'd2:    n.tnew = 2'd1;
        default: n.tnew = 2'd2;
      endcase
      n.reg_wreg  = e.reg_write ? e.reg_wreg : 5'd0;
      n.reg_write = e.valid ? e.reg_write : 1'b0;
      n.valid     = e.valid;
      if (e.valid) n.count = cur.count + 32'd1;
    end
    return with_fwd(n);
  endfunction

  function automatic e_t rand_e();
    e_t e;
    e.valid       = 1'($urandom_range(0, 1));
    e.pc          = $urandom;
    e.instruction = $urandom;
    e.data_rt     = $urandom;
    e.addr_rt     = 32'($urandom_range(0, 31));
    e.addr_rd     = 32'($urandom_range(0, 31));
    e.shift       = $urandom;
    e.alu_out     = $urandom;
    e.tnew        = 2'($urandom_range(0, 3));
    e.reg_wreg    = 5'($urandom_range(0, 31));
    e.reg_wd      = $urandom;
    e.reg_write   = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic e_t mk_e(input logic [31:0] pc, input logic [1:0] tnew,
                              input logic [4:0] wreg, input logic [31:0] wd,
                              input logic wr, input logic vld);
    e_t e = '0;
    e.valid       = vld;
    e.pc          = pc;
    e.instruction = 32'h0000_0021 | (32'(wreg) << 11);
    e.data_rt     = 32'hDEAD_0000 | pc;
    e.addr_rt     = 32'd9;
    e.addr_rd     = 32'(wreg);
    e.shift       = 32'h1234_0000;
    e.alu_out     = pc ^ 32'h5A5A_5A5A;
    e.tnew        = tnew;
    e.reg_wreg    = wreg;
    e.reg_wd      = wd;
    e.reg_write   = wr;
    return e;
  endfunction

  task automatic drive_e(input e_t e);
    bus.E_valid       = e.valid;
    bus.E_PC          = e.pc;
    bus.E_instruction = e.instruction;
    bus.E_data_rt     = e.data_rt;
    bus.E_addr_rt     = e.addr_rt;
    bus.E_addr_rd     = e.addr_rd;
    bus.E_Shift       = e.shift;
    bus.E_ALUout      = e.alu_out;
    bus.E_Tnew        = e.tnew;
    bus.E_RegWreg     = e.reg_wreg;
    bus.E_RegWD       = e.reg_wd;
    bus.E_RegWrite    = e.reg_write;
  endtask

  function automatic m_t sample();
    m_t m;
    m.pc          = bus.M_PC;
    m.instruction = bus.M_instruction;
    m.data_rt     = bus.M_data_rt;
    m.addr_rt     = bus.M_addr_rt;
    m.addr_rd     = bus.M_addr_rd;
    m.shift       = bus.M_Shift;
    m.alu_out     = bus.M_ALUout;
    m.tnew        = bus.M_Tnew;
    m.reg_wreg    = bus.M_RegWreg;
    m.reg_wd      = bus.M_RegWD;
    m.reg_write   = bus.M_RegWrite;
    m.valid       = bus.M_valid;
    m.fwd_ok      = bus.M_fwd_ok;
    m.count       = bus.M_count;
    return m;
  endfunction

  // Drive one cycle (called just after a falling edge), queue the model's
  // prediction, clock, then pop and compare on the next falling edge.
  task automatic apply(input string name, input logic en_v,
                       input logic flush_v, input e_t e);
    m_t exp_m, act_m;
    en    = en_v;
    flush = flush_v;
    drive_e(e);
    mdl = model_next(mdl, en_v, flush_v, e);
    sb_q.push_back(mdl);
    @(posedge clk);
    @(negedge clk);
    exp_m = sb_q.pop_front();
    act_m = sample();
    n_vec++;
    if (act_m !== exp_m) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act_m, exp_m);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m_t act_m;
    act_m = sample();
    n_vec++;
    if (act_m !== rst_m()) begin
      n_err++;
      $display("FAIL reset_initial: got %h expected %h", act_m, rst_m());
    end
    reset_n = 1'b1;
    apply("reset_preload", 1'b1, 1'b0, mk_e(32'h3010, 2'd0, 5'd3, 32'h77, 1'b1, 1'b1));
    // Assert reset between edges; outputs must clear without a clock.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    act_m = sample();
    n_vec++;
    if (act_m !== rst_m()) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", act_m, rst_m());
    end
    n_vec++;
    if (bus.M_fwd_ok !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fwd_ok: got %b expected 0", bus.M_fwd_ok);
    end
    mdl = rst_m();
    @(negedge clk);
    reset_n = 1'b1;   // released mid-cycle; next rising edge loads
  endtask

  task automatic test_load_aging();
    apply("load_addu", 1'b1, 1'b0, mk_e(32'h3000, 2'd1, 5'd8, 32'h1234, 1'b1, 1'b1));
    n_vec++;
    if (bus.M_Tnew !== 2'd0 || bus.M_RegWD !== 32'h1234 || bus.M_fwd_ok !== 1'b1 ||
        bus.M_count !== 32'd1) begin
      n_err++;
      $display("FAIL load_addu_fields: Tnew=%0d WD=%h fwd=%b cnt=%0d expected 0 1234 1 1",
               bus.M_Tnew, bus.M_RegWD, bus.M_fwd_ok, bus.M_count);
    end
    apply("load_lw", 1'b1, 1'b0, mk_e(32'h3004, 2'd2, 5'd9, 32'h0, 1'b1, 1'b1));
    n_vec++;
    if (bus.M_Tnew !== 2'd1 || bus.M_fwd_ok !== 1'b0) begin
      n_err++;
      $display("FAIL load_lw_fields: Tnew=%0d fwd=%b expected 1 0", bus.M_Tnew, bus.M_fwd_ok);
    end
    apply("load_tnew0", 1'b1, 1'b0, mk_e(32'h3008, 2'd0, 5'd10, 32'h55, 1'b1, 1'b1));
    n_vec++;
    if (bus.M_Tnew !== 2'd0 || bus.M_count !== 32'd3) begin
      n_err++;
      $display("FAIL load_tnew0_fields: Tnew=%0d cnt=%0d expected 0 3", bus.M_Tnew, bus.M_count);
    end
  endtask

  task automatic test_stall();
    apply("stall_load", 1'b1, 1'b0, mk_e(32'h3004, 2'd1, 5'd4, 32'h99, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      apply("stall_hold", 1'b0, 1'b0, rand_e());
      n_vec++;
      if (bus.M_PC !== 32'h3004 || bus.M_count !== 32'd4) begin
        n_err++;
        $display("FAIL stall_hold_%0d: PC=%h cnt=%0d expected 00003004 4", i, bus.M_PC, bus.M_count);
      end
    end
  endtask

  task automatic test_flush();
    apply("flush_pre", 1'b1, 1'b0, mk_e(32'h3040, 2'd0, 5'd7, 32'hABCD, 1'b1, 1'b1));
    apply("flush_en0", 1'b0, 1'b1, rand_e());
    n_vec++;
    if (bus.M_instruction !== 32'h0 || bus.M_RegWrite !== 1'b0 || bus.M_PC !== 32'h3000 ||
        bus.M_valid !== 1'b0 || bus.M_count !== 32'd5) begin
      n_err++;
      $display("FAIL flush_bubble: instr=%h wr=%b PC=%h valid=%b cnt=%0d expected 0 0 00003000 0 5",
               bus.M_instruction, bus.M_RegWrite, bus.M_PC, bus.M_valid, bus.M_count);
    end
    apply("flush_en1", 1'b1, 1'b1, mk_e(32'h3050, 2'd0, 5'd7, 32'h1, 1'b1, 1'b1));
  endtask

  task automatic test_invalid_dest();
    apply("invalid_slot", 1'b1, 1'b0, mk_e(32'h3060, 2'd0, 5'd6, 32'h1, 1'b1, 1'b0));
    n_vec++;
    if (bus.M_RegWrite !== 1'b0 || bus.M_count !== 32'd5) begin
      n_err++;
      $display("FAIL invalid_slot_fields: wr=%b cnt=%0d expected 0 5", bus.M_RegWrite, bus.M_count);
    end
    apply("dest_zero", 1'b1, 1'b0, mk_e(32'h3064, 2'd1, 5'd0, 32'h2, 1'b1, 1'b1));
    n_vec++;
    if (bus.M_fwd_ok !== 1'b0) begin
      n_err++;
      $display("FAIL dest_zero_fwd: got %b expected 0", bus.M_fwd_ok);
    end
    apply("no_write", 1'b1, 1'b0, mk_e(32'h3068, 2'd0, 5'd9, 32'h3, 1'b0, 1'b1));
    n_vec++;
    if (bus.M_RegWreg !== 5'd0 || bus.M_fwd_ok !== 1'b0) begin
      n_err++;
      $display("FAIL no_write_wreg: wreg=%0d fwd=%b expected 0 0", bus.M_RegWreg, bus.M_fwd_ok);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      apply("random_mix", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rand_e());
    end
  endtask

  task automatic test_count_wrap();
    en = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mdl = rst_m();
    bus4.E_valid = 1'b1;
    bus4.E_RegWrite = 1'b1;
    en4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus4.E_PC = 32'h3000 + 32'(i * 4);
      @(posedge clk);
      @(negedge clk);
      if (i == 15) begin
        n_vec++;
        if (bus4.M_count !== 4'd15) begin
          n_err++;
          $display("FAIL count_15: got %0d expected 15", bus4.M_count);
        end
      end
      if (i == 16) begin
        n_vec++;
        if (bus4.M_count !== 4'd0) begin
          n_err++;
          $display("FAIL count_wrap: got %0d expected 0", bus4.M_count);
        end
      end
    end
    en4 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    en4 = 1'b0;
    flush4 = 1'b0;
    drive_e('0);
    bus4.E_valid = 1'b0;  bus4.E_PC = '0;      bus4.E_instruction = '0;
    bus4.E_data_rt = '0;  bus4.E_addr_rt = '0; bus4.E_addr_rd = '0;
    bus4.E_Shift = '0;    bus4.E_ALUout = '0;  bus4.E_Tnew = '0;
    bus4.E_RegWreg = '0;  bus4.E_RegWD = '0;   bus4.E_RegWrite = 1'b0;
    mdl = rst_m();
    repeat (2) @(negedge clk);

    test_reset();
    test_load_aging();
    test_stall();
    test_flush();
    test_invalid_dest();
    test_back_to_back();
    test_count_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
